// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory controller: RV32I load/store
// funct3 codes, controller FSM states and the byte-lane write mask type.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic [3:0] lane_mask_t;

  // Expands a per-byte lane mask into a per-bit mask over a 32-bit word.
  function automatic logic [31:0] lane_bits(input lane_mask_t mask);
    logic [31:0] bits;
    bits = '0;
    for (int i = 0; i < 4; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus of the data-memory controller.
// Both channels are valid/ready: a request transfers on a rising edge with
// req_valid=1 and req_ready=1; a response transfers on a rising edge with
// rsp_valid=1 and rsp_ready=1, and rsp_* hold steady until then.
interface dmem_ctrl_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: store shift and byte mask, load extract and
// extend, funct3 legality and alignment. DMEM_MISALIGN_TRAP_EN makes
// misaligned halfword/word accesses errors instead of forcing alignment.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output lane_mask_t  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata
);

  logic        legal;
  logic        is_half;
  logic        is_word;
  logic [1:0]  lane;
  logic [4:0]  shamt;
  logic [31:0] shifted;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~we;
      default:          legal = 1'b0;
    endcase
  end

  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3[1:0] == 2'b10);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
  assign err      = ~legal | misalign;
  assign lane     = addr_lo;
`else
  // Misaligned accesses silently drop the low address bits.
  assign err  = ~legal;
  assign lane = is_word ? 2'b00 : (is_half ? {addr_lo[1], 1'b0} : addr_lo);
`endif

  assign shamt    = {lane, 3'b000};
  assign wdata_sh = wdata << shamt;
  assign shifted  = rword >> shamt;

  always_comb begin
    wmask = '0;
    if (we && !err) begin
      if (is_word)      wmask = 4'b1111;
      else if (is_half) wmask = 4'b0011 << lane;
      else              wmask = 4'b0001 << lane;
    end
  end

  always_comb begin
    rdata = '0;
    if (!we && !err) begin
      case (funct3)
        F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
        F3_BU:   rdata = {24'b0, shifted[7:0]};
        F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
        F3_HU:   rdata = {16'b0, shifted[15:0]};
        F3_W:    rdata = shifted;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Wait-state data-memory controller: one RV32I load/store in flight, response
// held until consumed. Optional DMEM_MISALIGN_TRAP_EN traps misaligned access.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  dmem_ctrl_if.slave bus,
  output state_t     dbg_state
);

  localparam int              DEPTH     = 2 ** (DM_ADDRESS - 2);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_ctrl: DATA_W must be 32");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_ctrl: WAIT_CYCLES must be in 0..15");
  end

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  do_access;

  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  acc_we;
  logic [2:0]            acc_f3;
  logic [DM_ADDRESS-1:0] acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic [DM_ADDRESS-3:0] word_idx;
  logic [DATA_W-1:0]     mem_rword;
  logic [DATA_W-1:0]     mem_wdata_d;
  logic                  mem_we;

  logic                  fmt_err;
  lane_mask_t            fmt_wmask;
  logic [DATA_W-1:0]     fmt_wdata;
  logic [DATA_W-1:0]     fmt_rdata;

  // With zero wait states the access happens on the accepting edge, so the
  // formatter must see the live request rather than the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = bus.req_we;
      acc_f3    = bus.req_funct3;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_we    = we_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign word_idx  = acc_addr[DM_ADDRESS-1:2];
  assign mem_rword = mem_q[word_idx];

  dmem_lane_fmt u_fmt (
    .we       (acc_we),
    .funct3   (acc_f3),
    .addr_lo  (acc_addr[1:0]),
    .wdata    (acc_wdata),
    .rword    (mem_rword),
    .err      (fmt_err),
    .wmask    (fmt_wmask),
    .wdata_sh (fmt_wdata),
    .rdata    (fmt_rdata)
  );

  assign mem_wdata_d = (mem_rword & ~lane_bits(fmt_wmask)) | (fmt_wdata & lane_bits(fmt_wmask));
  // An access edge that coincides with reset is cancelled.
  assign mem_we      = do_access && acc_we && !fmt_err && !reset;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          do_access = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_access) begin
      rdata_d = fmt_rdata;
      err_d   = fmt_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_idx] <= mem_wdata_d;
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DM_ADDRESS, default 9, byte-address width; storage depth 2**(DM_ADDRESS-2) words.
REQ-002 Parameter DATA_W, default 32, word width; 32 is the only legal value, and elaboration SHALL fail otherwise.
REQ-003 Parameter WAIT_CYCLES, default 1, extra access wait states; legal range 0..15.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port req_valid  input  1  request present.
REQ-007 Port req_ready  output  1  controller can accept a request.
REQ-008 Port req_we  input  1  1 = store, 0 = load.
REQ-009 Port req_funct3  input  3  access size/sign, RV32I load/store encoding.
REQ-010 Port req_addr  input  DM_ADDRESS  byte address.
REQ-011 Port req_wdata  input  DATA_W  store data, right-aligned.
REQ-012 Port rsp_valid  output  1  response present.
REQ-013 Port rsp_ready  input  1  consumer takes response.
REQ-014 Port rsp_rdata  output  DATA_W  load result, extended; 0 for stores and errors.
REQ-015 Port rsp_err  output  1  request was misaligned or illegal.

Function
REQ-016 FSM states: IDLE, WAIT, RESP. req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-017 A request is accepted on a rising edge with req_valid=1 in IDLE; all req_* fields SHALL be latched at that edge.
REQ-018 On acceptance, the FSM SHALL go to WAIT with counter=WAIT_CYCLES, or straight to the access step when WAIT_CYCLES=0.
REQ-019 In WAIT, the counter SHALL decrement each cycle; the access step SHALL occur on the edge where the counter is 1.
REQ-020 The access step SHALL perform the write or register the read data and error flag, then enter RESP.
REQ-021 With a response-ready consumer, the first rsp_valid cycle SHALL come WAIT_CYCLES+1 cycles after acceptance.
REQ-022 In RESP, rsp_* SHALL stay stable until rsp_ready=1; on that edge the FSM SHALL return to IDLE. Back-to-back throughput SHALL be one request per WAIT_CYCLES+2 cycles.
REQ-023 Loads: LB(000) and LH(001) SHALL be sign-extended; LBU(100) and LHU(101) zero-extended; LW(010) taken whole. Lane = req_addr[1:0].
REQ-024 Stores: SB(000), SH(001), SW(010) SHALL write only the addressed byte lanes, with req_wdata low bytes shifted to the lanes; other bytes are preserved.
REQ-025 Illegal funct3 (loads 011/110/111; stores 011..111) SHALL set rsp_err=1, rsp_rdata=0, and perform no write.
REQ-026 req_valid in any non-IDLE state SHALL be ignored and not queued.

Reset
REQ-027 On reset: state=IDLE, counter=0, rsp_rdata=0, rsp_err=0, hence req_ready=1 and rsp_valid=0 in the following cycle.
REQ-028 Reset in WAIT SHALL cancel the pending store with no memory change; reset in RESP SHALL discard the response.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DMEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1, or word with addr[1:0]!=0, SHALL set rsp_err=1, rsp_rdata=0, and perform no write.
REQ-031 Macro undefined: misaligned accesses SHALL force the low address bits to zero (halfword: addr[0]; word: addr[1:0]), complete normally, and keep rsp_err=0.

Structure
REQ-032 Package dmem_pkg SHALL hold the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), the FSM state enum, and the byte-lane mask type.
REQ-033 Sub-module dmem_lane_fmt SHALL be purely combinational: store lane shift and byte mask, load extract and extend, legality and alignment checks.

Verification
REQ-034 SW 0xDEADBEEF @0x10, then LB @0x13 -> rsp_rdata=0xFFFFFFDE, rsp_err=0; LBU @0x13 -> 0x000000DE.
REQ-035 SH 0x1234 @0x12 over 0xDEADBEEF, then LW @0x10 -> 0x1234BEEF; LH @0x10 -> 0xFFFFBEEF.
REQ-036 WAIT_CYCLES=3, rsp_ready held 0 for 5 cycles -> rsp_valid at acceptance+4, rdata stable, req_ready=0 throughout.
REQ-037 SW @0x21 -> with macro: rsp_err=1 and word @0x20 unchanged; without macro: word @0x20 written, rsp_err=0.
REQ-038 SW 0x55 @0x30 with reset asserted in WAIT -> after reset, LW @0x30 returns the prior value; req_ready=1 the cycle after reset.
REQ-039 Load with funct3=011 -> rsp_err=1, rsp_rdata=0; the FSM returns to IDLE after the rsp_ready handshake.
